raster_stamp_dispatch: RTL and testbench

- Shares one raster unit stamp output stream among NUM_CORES per-core raster agents.
- Each agent raises a request when a warp executes a stamp-pop. The dispatcher grants round-robin, forwards one stamp packet per grant into a per-core response slot, and latches end-of-frame.
- After end-of-frame, every further request is answered locally with a done packet until the next frame starts.
- Sits between the raster unit output and the cores' raster bus inputs.

---
 rtl/raster_stamp_dispatch_pkg.sv | 15 +
 rtl/raster_stamp_dispatch_if.sv | 33 +++
 rtl/raster_rr_arbiter.sv | 41 ++++
 rtl/raster_stamp_dispatch.sv | 94 +++++++++
 tb/tb_raster_stamp_dispatch.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/raster_stamp_dispatch_pkg.sv
// Shared raster dispatch types: default packet geometry, dispatch state, counter width.
package raster_stamp_dispatch_pkg;

  localparam int RSD_NUM_LANES = 4;
  localparam int RSD_STAMP_W   = 64;
  localparam int CNT_W         = 32;

  typedef enum logic {ST_RUN, ST_DONE} disp_state_e;

  typedef struct packed {
    logic [RSD_NUM_LANES-1:0][RSD_STAMP_W-1:0] stamps;
    logic                                      done;
  } stamp_pkt_t;

endpackage

// File: rtl/raster_stamp_dispatch_if.sv
// Raster unit source stream plus per-core response slots, seen from the dispatcher.
interface raster_stamp_dispatch_if
  import raster_stamp_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_LANES = RSD_NUM_LANES,
  parameter int STAMP_W   = RSD_STAMP_W
) ();

  logic                                              frame_start;
  logic                                              src_valid;
  logic [NUM_LANES-1:0][STAMP_W-1:0]                 src_data;
  logic                                              src_done;
  logic                                              src_ready;
  logic [NUM_CORES-1:0]                              core_req_valid;
  logic [NUM_CORES-1:0]                              core_rsp_valid;
  logic [NUM_CORES-1:0][NUM_LANES-1:0][STAMP_W-1:0]  core_rsp_data;
  logic [NUM_CORES-1:0]                              core_rsp_done;
  logic [NUM_CORES-1:0]                              core_rsp_ready;
  logic                                              busy;
  logic [CNT_W-1:0]                                  stamp_count;

  modport slave (
    input  frame_start, src_valid, src_data, src_done, core_req_valid, core_rsp_ready,
    output src_ready, core_rsp_valid, core_rsp_data, core_rsp_done, busy, stamp_count
  );

  modport master (
    output frame_start, src_valid, src_data, src_done, core_req_valid, core_rsp_ready,
    input  src_ready, core_rsp_valid, core_rsp_data, core_rsp_done, busy, stamp_count
  );

endinterface

// File: rtl/raster_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; pointer moves past the winner.
module raster_rr_arbiter #(
  parameter  int NUM_REQS = 4,
  localparam int IW       = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                gnt_en,
  input  logic                ptr_upd,
  output logic [NUM_REQS-1:0] gnt,
  output logic [IW-1:0]       gnt_idx
);

  logic [IW-1:0] rr_ptr;
  logic          found;
  int            c;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQS) c = c - NUM_REQS;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt_idx = IW'(c);
      end
    end
    gnt = (found && gnt_en) ? (NUM_REQS'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (ptr_upd && found)
      rr_ptr <= (gnt_idx == IW'(NUM_REQS-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/raster_stamp_dispatch.sv
// Shares one raster stamp stream among NUM_CORES response slots; after end-of-frame
// every further request is answered locally with a done packet until frame_start.
module raster_stamp_dispatch
  import raster_stamp_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_LANES = RSD_NUM_LANES,
  parameter int STAMP_W   = RSD_STAMP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  raster_stamp_dispatch_if.slave  bus
);

  localparam int IW = $clog2(NUM_CORES);

  disp_state_e                                      state;
  logic [NUM_CORES-1:0]                             slot_vld, slot_done, elig, gnt;
  logic [NUM_CORES-1:0][NUM_LANES-1:0][STAMP_W-1:0] slot_data;
  logic [CNT_W-1:0]                                 cnt;
  logic [IW-1:0]                                    win_idx;
  logic                                             fire;

  // A slot draining this cycle is still full, so its core is not regranted until next cycle.
  assign elig          = bus.core_req_valid & ~slot_vld;
  assign bus.src_ready = (state == ST_RUN) && (|elig);
  assign fire          = bus.src_valid & bus.src_ready;

  raster_rr_arbiter #(.NUM_REQS(NUM_CORES)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .gnt_en  (fire),
    .ptr_upd (fire),
    .gnt     (gnt),
    .gnt_idx (win_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld  <= '0;
      slot_done <= '0;
      slot_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (slot_vld[i] && bus.core_rsp_ready[i]) begin
          slot_vld[i]  <= 1'b0;
          slot_done[i] <= 1'b0;
        end else if (state == ST_DONE && elig[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_done[i] <= 1'b1;
          slot_data[i] <= '0;
        end else if (gnt[i]) begin
          slot_vld[i]  <= 1'b1;
        end
      end
      // Winner slot is empty by construction, so this never collides with a drain.
      if (fire) begin
        slot_data[win_idx] <= bus.src_data;
        slot_done[win_idx] <= bus.src_done;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (fire) begin
            if (bus.src_done) state <= ST_DONE;
            else              cnt   <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.frame_start) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.core_rsp_valid = slot_vld;
  assign bus.core_rsp_data  = slot_data;
  assign bus.core_rsp_done  = slot_done;
  assign bus.busy           = |slot_vld;
  assign bus.stamp_count    = cnt;

endmodule

// File: tb/tb_raster_stamp_dispatch.sv
// Directed table-driven bench for raster_stamp_dispatch (4 cores, 4 lanes x 64b).
module tb_raster_stamp_dispatch;

  logic clk, reset;
  int   total, bad;

  raster_stamp_dispatch_if #(.NUM_CORES(4), .NUM_LANES(4), .STAMP_W(64)) bus ();

  raster_stamp_dispatch #(.NUM_CORES(4), .NUM_LANES(4), .STAMP_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      req;
    logic            sv;
    logic [7:0]      tag;
    logic            sd;
    logic [3:0]      rdy;
    logic            fs;
    logic            srdy;
    logic [3:0]      vld;
    logic [3:0]      dn;
    logic [31:0]     cnt;
    logic [3:0][7:0] etag;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [255:0] mk(input logic [7:0] t);
    return {32{t}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic sv, input logic [7:0] tag,
                       input logic sd, input logic [3:0] rdy, input logic fs);
    bus.core_req_valid = req;
    bus.src_valid      = sv;
    bus.src_data       = mk(tag);
    bus.src_done       = sd;
    bus.core_rsp_ready = rdy;
    bus.frame_start    = fs;
  endtask

  task automatic run_row(input int k);
    vec_t v;
    v = tbl[k];
    drive(v.req, v.sv, v.tag, v.sd, v.rdy, v.fs);
    #1;
    chk($sformatf("r%0d src_ready", k), 256'(bus.src_ready), 256'(v.srdy));
    @(posedge clk); #1;
    chk($sformatf("r%0d rsp_valid", k), 256'(bus.core_rsp_valid), 256'(v.vld));
    chk($sformatf("r%0d rsp_done", k), 256'(bus.core_rsp_done), 256'(v.dn));
    chk($sformatf("r%0d busy", k), 256'(bus.busy), 256'(|v.vld));
    chk($sformatf("r%0d stamp_count", k), 256'(bus.stamp_count), 256'(v.cnt));
    for (int i = 0; i < 4; i++)
      if (v.vld[i]) chk($sformatf("r%0d data%0d", k, i), bus.core_rsp_data[i], mk(v.etag[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    //            req    sv    tag    sd    rdy    fs    srdy  vld      dn       cnt     etag
    tbl[0]  = '{4'hF, 1'b1, 8'h10, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'd1,  32'h00000010};
    tbl[1]  = '{4'hF, 1'b1, 8'h11, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0010, 4'b0000, 32'd2,  32'h00001100};
    tbl[2]  = '{4'hF, 1'b1, 8'h12, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0100, 4'b0000, 32'd3,  32'h00120000};
    tbl[3]  = '{4'hF, 1'b1, 8'h13, 1'b0, 4'hF, 1'b0, 1'b1, 4'b1000, 4'b0000, 32'd4,  32'h13000000};
    tbl[4]  = '{4'hF, 1'b1, 8'h14, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'd5,  32'h00000014};
    tbl[5]  = '{4'hF, 1'b1, 8'h15, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0010, 4'b0000, 32'd6,  32'h00001500};
    tbl[6]  = '{4'hF, 1'b1, 8'h16, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0100, 4'b0000, 32'd7,  32'h00160000};
    tbl[7]  = '{4'hF, 1'b1, 8'h17, 1'b0, 4'hF, 1'b0, 1'b1, 4'b1000, 4'b0000, 32'd8,  32'h17000000};
    tbl[8]  = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'd8,  32'h00000000};
    // core 2 stalls with a full slot and keeps requesting; it must be skipped untouched
    tbl[9]  = '{4'h4, 1'b1, 8'h20, 1'b0, 4'h0, 1'b0, 1'b1, 4'b0100, 4'b0000, 32'd9,  32'h00200000};
    tbl[10] = '{4'hF, 1'b1, 8'h21, 1'b0, 4'hB, 1'b0, 1'b1, 4'b1100, 4'b0000, 32'd10, 32'h21200000};
    tbl[11] = '{4'hF, 1'b1, 8'h22, 1'b0, 4'hB, 1'b0, 1'b1, 4'b0101, 4'b0000, 32'd11, 32'h00200022};
    tbl[12] = '{4'hF, 1'b1, 8'h23, 1'b0, 4'hB, 1'b0, 1'b1, 4'b0110, 4'b0000, 32'd12, 32'h00202300};
    tbl[13] = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'd12, 32'h00000000};
    // end-of-frame to core 1 while 0 and 3 wait, then local done packets
    tbl[14] = '{4'h1, 1'b1, 8'h30, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0001, 4'b0000, 32'd13, 32'h00000030};
    tbl[15] = '{4'hB, 1'b1, 8'h31, 1'b1, 4'hF, 1'b0, 1'b1, 4'b0010, 4'b0010, 32'd13, 32'h00003100};
    tbl[16] = '{4'hB, 1'b1, 8'h32, 1'b0, 4'hF, 1'b0, 1'b0, 4'b1001, 4'b1001, 32'd13, 32'h00000000};
    tbl[17] = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'd13, 32'h00000000};
    // frame_start re-arms only in DONE
    tbl[18] = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'd0,  32'h00000000};
    tbl[19] = '{4'h4, 1'b1, 8'h40, 1'b0, 4'hF, 1'b0, 1'b1, 4'b0100, 4'b0000, 32'd1,  32'h00400000};
    tbl[20] = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'd1,  32'h00000000};
    tbl[21] = '{4'h1, 1'b1, 8'h41, 1'b1, 4'hF, 1'b1, 1'b1, 4'b0001, 4'b0001, 32'd1,  32'h00000041};
    tbl[22] = '{4'h8, 1'b1, 8'h42, 1'b0, 4'hF, 1'b0, 1'b0, 4'b1000, 4'b1000, 32'd1,  32'h00000000};
    tbl[23] = '{4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'd0,  32'h00000000};

    // reset state
    reset = 1'b0;
    drive(4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst rsp_valid", 256'(bus.core_rsp_valid), 256'(0));
    chk("rst rsp_done", 256'(bus.core_rsp_done), 256'(0));
    for (int i = 0; i < 4; i++) chk($sformatf("rst data%0d", i), bus.core_rsp_data[i], 256'(0));
    chk("rst busy", 256'(bus.busy), 256'(0));
    chk("rst stamp_count", 256'(bus.stamp_count), 256'(0));
    chk("rst src_ready", 256'(bus.src_ready), 256'(0));
    reset = 1'b1;

    // single packet A to core 0, one-cycle latency
    drive(4'h1, 1'b1, 8'h0A, 1'b0, 4'h0, 1'b0);
    #1;
    chk("A src_ready", 256'(bus.src_ready), 256'(1));
    chk("A pre-edge valid", 256'(bus.core_rsp_valid), 256'(0));
    @(posedge clk); #1;
    chk("A rsp_valid", 256'(bus.core_rsp_valid), 256'(4'b0001));
    chk("A data0", bus.core_rsp_data[0], mk(8'h0A));
    chk("A done", 256'(bus.core_rsp_done), 256'(0));
    chk("A stamp_count", 256'(bus.stamp_count), 256'(1));
    drive(4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk("A drained", 256'(bus.core_rsp_valid), 256'(0));
    reset = 1'b0;
    #2;
    reset = 1'b1;

    for (int k = 0; k < 24; k++) run_row(k);

    // fill three slots (grants 1,2,0 from pointer 1), then async reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      drive(4'h7, 1'b1, 8'h50 + 8'(k), 1'b0, 4'h0, 1'b0);
      @(posedge clk); #1;
    end
    chk("fill rsp_valid", 256'(bus.core_rsp_valid), 256'(4'b0111));
    chk("fill stamp_count", 256'(bus.stamp_count), 256'(3));
    reset = 1'b0;
    #2;
    chk("async rst valid", 256'(bus.core_rsp_valid), 256'(0));
    chk("async rst busy", 256'(bus.busy), 256'(0));
    chk("async rst count", 256'(bus.stamp_count), 256'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    drive(4'h3, 1'b1, 8'h60, 1'b0, 4'h0, 1'b0);
    #1;
    chk("post rst src_ready", 256'(bus.src_ready), 256'(1));
    @(posedge clk); #1;
    chk("post rst grant", 256'(bus.core_rsp_valid), 256'(4'b0001));
    chk("post rst data0", bus.core_rsp_data[0], mk(8'h60));
    chk("post rst count", 256'(bus.stamp_count), 256'(1));
    drive(4'h0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
